// File: rtl/usb_link_state.sv
// usb_link_state: USB FS/LS link-state monitor (bus reset, suspend, host resume, remote wakeup)
// Ports: clk/rst (async, active-high); rx_dp/rx_dn synchronised line; rx_activity packet start;
//        rwu_ena/rwu_req remote-wakeup enable and request; usb_rst/suspend status levels;
//        evt_reset/evt_suspend/evt_resume one-cycle events; tx_dp/tx_dn/tx_en wakeup K drive;
//        link_state 0=RESET 1=ACTIVE 2=SUSPEND 3=RESUME_HOST 4=RWU_DRIVE.
// Optional: define USB_LINK_LS_EN for low-speed J/K polarity.
module usb_link_state #(
    parameter int CLK_KHZ         = 48000,
    parameter int T_RESET_US      = 2500,
    parameter int T_SUSPEND_US    = 3000,
    parameter int T_RESUME_DET_US = 20,
    parameter int T_RWU_IDLE_US   = 5000,
    parameter int T_RWU_K_US      = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_dp,
    input  logic       rx_dn,
    input  logic       rx_activity,
    input  logic       rwu_ena,
    input  logic       rwu_req,
    output logic       usb_rst,
    output logic       suspend,
    output logic       evt_reset,
    output logic       evt_suspend,
    output logic       evt_resume,
    output logic       tx_dp,
    output logic       tx_dn,
    output logic       tx_en,
    output logic [2:0] link_state
);
    localparam int N_RST = CLK_KHZ * T_RESET_US / 1000;
    localparam int N_SUS = CLK_KHZ * T_SUSPEND_US / 1000;
    localparam int N_RD  = CLK_KHZ * T_RESUME_DET_US / 1000;
    localparam int N_IDL = CLK_KHZ * T_RWU_IDLE_US / 1000;
    localparam int N_RWK = CLK_KHZ * T_RWU_K_US / 1000;
    localparam int N_M1  = N_RST > N_SUS ? N_RST : N_SUS;
    localparam int N_M2  = N_M1 > N_RD ? N_M1 : N_RD;
    localparam int N_M3  = N_M2 > N_IDL ? N_M2 : N_IDL;
    localparam int N_MAX = N_M3 > N_RWK ? N_M3 : N_RWK;
    localparam int TW    = $clog2(N_MAX + 1);
    localparam logic [TW-1:0] C_RST = TW'(N_RST);
    localparam logic [TW-1:0] C_SUS = TW'(N_SUS);
    localparam logic [TW-1:0] C_RD  = TW'(N_RD);
    localparam logic [TW-1:0] C_IDL = TW'(N_IDL);
    localparam logic [TW-1:0] C_RWK = TW'(N_RWK);

    typedef enum logic [2:0] {
        S_RESET   = 3'd0,
        S_ACTIVE  = 3'd1,
        S_SUSPEND = 3'd2,
        S_RESUME  = 3'd3,
        S_RWU     = 3'd4
    } state_t;

    state_t        r_state, w_fsm, w_next;
    logic [TW-1:0] r_se0_cnt, r_tmr, r_k_cnt, w_se0_cnt, w_tmr, w_k_cnt;
    logic          r_rwu_pend, w_se0, w_j, w_k, w_rst_hit;

    assign w_se0 = ~rx_dp & ~rx_dn;
`ifdef USB_LINK_LS_EN
    localparam logic RWU_DP = 1'b1;
    assign w_j = ~rx_dp & rx_dn;
    assign w_k = rx_dp & ~rx_dn;
`else
    localparam logic RWU_DP = 1'b0;
    assign w_j = rx_dp & ~rx_dn;
    assign w_k = ~rx_dp & rx_dn;
`endif

    assign link_state = r_state;

    // Counter values are the post-edge values; thresholds compare against them so
    // an N-cycle condition acts on the Nth qualifying edge.
    always_comb begin
        w_se0_cnt = (w_se0 && r_state != S_RWU) ? ((r_se0_cnt >= C_RST) ? C_RST : r_se0_cnt + TW'(1)) : '0;
        w_k_cnt   = w_k ? ((&r_k_cnt) ? r_k_cnt : r_k_cnt + TW'(1)) : '0;
        w_tmr     = (r_state == S_ACTIVE && (!w_j || rx_activity)) ? '0 : ((&r_tmr) ? r_tmr : r_tmr + TW'(1));
        w_rst_hit = w_se0_cnt >= C_RST && (r_state == S_ACTIVE || r_state == S_SUSPEND || r_state == S_RESUME);
        w_fsm     = r_state;
        case (r_state)
            S_RESET:   w_fsm = w_se0 ? S_RESET : S_ACTIVE;
            S_ACTIVE:  w_fsm = (w_tmr >= C_SUS) ? S_SUSPEND : S_ACTIVE;
            S_SUSPEND: w_fsm = (w_k_cnt >= C_RD) ? S_RESUME : (r_rwu_pend && w_tmr >= C_IDL) ? S_RWU : S_SUSPEND;
            S_RESUME:  w_fsm = w_j ? S_ACTIVE : S_RESUME;
            S_RWU:     w_fsm = (w_tmr >= C_RWK) ? S_RESUME : S_RWU;
            default:   w_fsm = S_RESET;
        endcase
        w_next    = w_rst_hit ? S_RESET : w_fsm;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_RESET;
            r_se0_cnt   <= '0;
            r_tmr       <= '0;
            r_k_cnt     <= '0;
            r_rwu_pend  <= 1'b0;
            usb_rst     <= 1'b1;
            suspend     <= 1'b0;
            evt_reset   <= 1'b0;
            evt_suspend <= 1'b0;
            evt_resume  <= 1'b0;
            tx_en       <= 1'b0;
            tx_dp       <= 1'b0;
            tx_dn       <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_se0_cnt   <= w_se0_cnt;
            r_k_cnt     <= w_k_cnt;
            r_tmr       <= (w_next != r_state) ? '0 : w_tmr;
            // A pending wakeup only survives while the link stays suspended.
            r_rwu_pend  <= r_state == S_SUSPEND && w_next == S_SUSPEND && (r_rwu_pend || (rwu_req && rwu_ena));
            usb_rst     <= w_next == S_RESET;
            suspend     <= w_next == S_SUSPEND || w_next == S_RESUME || w_next == S_RWU;
            evt_reset   <= w_next == S_RESET && r_state != S_RESET;
            evt_suspend <= w_next == S_SUSPEND && r_state != S_SUSPEND;
            evt_resume  <= r_state == S_RESUME && w_next == S_ACTIVE;
            tx_en       <= w_next == S_RWU;
            tx_dp       <= w_next == S_RWU && RWU_DP;
            tx_dn       <= w_next == S_RWU && !RWU_DP;
        end
    end
endmodule

// File: tb/tb_usb_link_state.sv
// tb_usb_link_state: directed checks of reset, suspend, resume and remote wakeup timing
module tb_usb_link_state;
    logic       clk = 1'b0, rst = 1'b1;
    logic       rx_dp = 1'b0, rx_dn = 1'b0, rx_activity = 1'b0, rwu_ena = 1'b0, rwu_req = 1'b0;
    logic       usb_rst, suspend, evt_reset, evt_suspend, evt_resume, tx_dp, tx_dn, tx_en;
    logic [2:0] link_state;
    int         n_chk = 0, n_err = 0;

    usb_link_state #(.CLK_KHZ(1000)) dut (
        .clk(clk), .rst(rst), .rx_dp(rx_dp), .rx_dn(rx_dn), .rx_activity(rx_activity),
        .rwu_ena(rwu_ena), .rwu_req(rwu_req), .usb_rst(usb_rst), .suspend(suspend),
        .evt_reset(evt_reset), .evt_suspend(evt_suspend), .evt_resume(evt_resume),
        .tx_dp(tx_dp), .tx_dn(tx_dn), .tx_en(tx_en), .link_state(link_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_line(input logic dp, input logic dn);
        rx_dp = dp;
        rx_dn = dn;
    endtask

    task automatic pulse_req();
        rwu_req = 1'b1;
        tick(1);
        rwu_req = 1'b0;
    endtask

    initial begin
        int bad;
        set_line(0, 0);
        tick(2);
        check("rst_state", link_state, 0);
        check("rst_usb_rst", usb_rst, 1);
        check("rst_suspend", suspend, 0);
        check("rst_tx", {tx_en, tx_dp, tx_dn}, 0);
        check("rst_evt", {evt_reset, evt_suspend, evt_resume}, 0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 2600; i++) begin
            tick(1);
            if (usb_rst !== 1'b1 || evt_reset !== 1'b0 || link_state !== 3'd0) bad++;
        end
        check("se0_hold_reset", bad, 0);
        set_line(1, 0);
        tick(1);
        check("exit_reset_state", link_state, 1);
        check("exit_reset_usb_rst", usb_rst, 0);
        check("exit_reset_no_evt", evt_reset, 0);
        tick(2999);
        check("idle_2999_state", link_state, 1);
        tick(1);
        check("idle_3000_state", link_state, 2);
        check("idle_3000_suspend", suspend, 1);
        check("idle_3000_evt", evt_suspend, 1);
        tick(1);
        check("evt_suspend_one_cycle", evt_suspend, 0);
        set_line(0, 1);
        tick(19);
        check("k19_state", link_state, 2);
        tick(1);
        check("k20_state", link_state, 3);
        check("k20_suspend", suspend, 1);
        set_line(0, 0);
        tick(2);
        check("eop_hold", link_state, 3);
        set_line(1, 0);
        tick(1);
        check("resume_state", link_state, 1);
        check("resume_evt", evt_resume, 1);
        check("resume_suspend", suspend, 0);
        tick(1);
        check("evt_resume_one_cycle", evt_resume, 0);
        tick(2997);
        rx_activity = 1'b1;
        tick(1);
        rx_activity = 1'b0;
        check("act_2999_state", link_state, 1);
        tick(1);
        check("act_3000_state", link_state, 1);
        tick(2998);
        check("act_5998_state", link_state, 1);
        tick(1);
        check("act_5999_state", link_state, 2);
        check("act_5999_evt", evt_suspend, 1);
        rwu_ena = 1'b1;
        tick(99);
        pulse_req();
        tick(4899);
        check("rwu_4999_tx_en", tx_en, 0);
        check("rwu_4999_state", link_state, 2);
        tick(1);
        check("rwu_5000_tx_en", tx_en, 1);
        check("rwu_5000_drive", {tx_dp, tx_dn}, 2'b01);
        check("rwu_5000_state", link_state, 4);
        tick(1999);
        check("rwu_k_1999_tx_en", tx_en, 1);
        tick(1);
        check("rwu_k_2000_tx_en", tx_en, 0);
        check("rwu_k_2000_state", link_state, 3);
        tick(1);
        check("rwu_resume_state", link_state, 1);
        check("rwu_resume_evt", evt_resume, 1);
        tick(3000);
        check("second_suspend", link_state, 2);
        rwu_ena = 1'b0;
        tick(99);
        pulse_req();
        bad = 0;
        for (int i = 0; i < 6000; i++) begin
            tick(1);
            if (tx_en !== 1'b0 || link_state !== 3'd2) bad++;
        end
        check("rwu_disabled_no_tx", bad, 0);
        set_line(0, 0);
        tick(2499);
        check("se0_2499_state", link_state, 2);
        tick(1);
        check("se0_2500_state", link_state, 0);
        check("se0_2500_evt", evt_reset, 1);
        check("se0_2500_usb_rst", usb_rst, 1);
        check("se0_2500_suspend", suspend, 0);
        tick(1);
        check("evt_reset_one_cycle", evt_reset, 0);
        set_line(1, 0);
        tick(1);
        check("reexit_reset", link_state, 1);
        tick(3000);
        check("third_suspend", link_state, 2);
        set_line(0, 1);
        tick(19);
        set_line(1, 0);
        tick(6);
        check("k19_no_resume", link_state, 2);
        rwu_ena = 1'b1;
        pulse_req();
        for (int i = 0; i < 6000 && link_state != 3'd4; i++) tick(1);
        check("rwu_enter", link_state, 4);
        tick(500);
        check("rwu_mid_tx_en", tx_en, 1);
        #2 rst = 1'b1;
        #1;
        check("async_tx_en", tx_en, 0);
        check("async_state", link_state, 0);
        check("async_usb_rst", usb_rst, 1);
        check("async_suspend", suspend, 0);
        check("async_drive", {tx_dp, tx_dn}, 0);
        tick(1);
        rst = 1'b0;
        tick(1);
        check("post_async_evt", evt_reset, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/usb_link_state.md
Name: usb_link_state

Overview:
Parametrised USB full/low-speed link-state monitor and controller for the USB core.
- Detects bus reset (long SE0), suspend (bus idle) and host-driven resume (K state).
- Generates device remote-wakeup K signalling.
- Drives the core logic reset and suspend status; the top level muxes its tx outputs into the PHY alongside the TX low-level block.
- All durations are parameters in microseconds, converted to cycles from CLK_KHZ.

Parameters:
- CLK_KHZ, 48000, core clock frequency in kHz; cycles(T) = CLK_KHZ*T/1000.
- T_RESET_US, 2500, continuous SE0 duration that declares bus reset.
- T_SUSPEND_US, 3000, continuous idle J duration that declares suspend.
- T_RESUME_DET_US, 20, continuous K duration in SUSPEND that declares host resume.
- T_RWU_IDLE_US, 5000, minimum time in SUSPEND before remote wakeup may be driven.
- T_RWU_K_US, 2000, duration of the device-driven remote-wakeup K.
- TW, auto, counter width = $clog2(largest cycle count + 1).

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- rx_dp  in  1  synchronised D+ from PHY
- rx_dn  in  1  synchronised D- from PHY
- rx_activity  in  1  pulse on any packet start (rxpkt_start)
- rwu_ena  in  1  remote wakeup enabled by host (config register)
- rwu_req  in  1  one-cycle software remote-wakeup request
- usb_rst  out  1  core logic reset, level
- suspend  out  1  link suspended, level
- evt_reset  out  1  one-cycle pulse on entering RESET from any state
- evt_suspend  out  1  one-cycle pulse on entering SUSPEND
- evt_resume  out  1  one-cycle pulse on RESUME_HOST -> ACTIVE
- tx_dp  out  1  D+ drive value
- tx_dn  out  1  D- drive value
- tx_en  out  1  drive enable, remote wakeup only
- link_state  out  3  current state encoding

Behaviour:
- Line decode, combinational from rx_dp/rx_dn:
  - SE0 = both low.
  - Full speed: J = dp&~dn, K = ~dp&dn.
  - SE1 is treated as non-idle and non-K.
- States and link_state encoding: RESET=0, ACTIVE=1, SUSPEND=2, RESUME_HOST=3, RWU_DRIVE=4. All outputs are registered.
- Async rst:
  - state=RESET, usb_rst=1, suspend=0, tx_en=0, tx_dp=0, tx_dn=0, all evt=0, counters cleared, rwu_pend=0.
  - No evt_reset is emitted on async reset.
- se0_cnt:
  - Increments while SE0 and state!=RWU_DRIVE, clears otherwise.
  - Saturates at cycles(T_RESET_US).
  - On reaching it in ACTIVE/SUSPEND/RESUME_HOST: next state RESET, evt_reset=1 for one cycle.
  - Reset has priority over every other same-cycle transition.
- RESET: usb_rst=1, suspend=0. Exits to ACTIVE on the first non-SE0 cycle; usb_rst drops the same edge the state changes.
- ACTIVE:
  - tmr counts cycles while J; clears on non-J or rx_activity.
  - tmr reaching cycles(T_SUSPEND_US) -> SUSPEND, evt_suspend=1, suspend=1.
- SUSPEND:
  - tmr restarts at 0 on entry and counts elapsed suspend time, saturating.
  - A separate k_cnt counts continuous K and clears on non-K.
  - k_cnt reaching cycles(T_RESUME_DET_US) -> RESUME_HOST.
  - rwu_req in SUSPEND with rwu_ena=1 sets rwu_pend. rwu_req outside SUSPEND, or with rwu_ena=0, is ignored.
  - rwu_pend and tmr>=cycles(T_RWU_IDLE_US) -> RWU_DRIVE. Host resume detection wins if both occur in the same cycle, and rwu_pend is cleared.
- RWU_DRIVE:
  - tx_en=1, drives K (tx_dp=0, tx_dn=1); line inputs are ignored.
  - tmr counts to cycles(T_RWU_K_US), then tx_en=0 -> RESUME_HOST.
  - rwu_pend clears on entry.
- RESUME_HOST:
  - suspend stays 1.
  - First J cycle -> ACTIVE, suspend=0, evt_resume=1.
  - SE0 (host EOP) holds the state; it only exits via se0_cnt timeout to RESET.
- Counter comparisons use >= on TW-bit unsigned values; no wrap-around, all counters saturate.

Optional Feature:
- Macro USB_LINK_LS_EN.
- Defined: low-speed polarity, so J = ~dp&dn and K = dp&~dn; remote-wakeup K drives tx_dp=1, tx_dn=0.
- Undefined: full-speed polarity as in Behaviour.
- All timing is unchanged in both cases.

Test Plan:
All scenarios use CLK_KHZ=1000 (1 cycle = 1 us) and default durations.
1. rst released with line SE0 for 2600 cycles, then J -> usb_rst=1 throughout, ACTIVE with usb_rst=0 one cycle after J appears, no evt_reset.
2. ACTIVE with J idle 3000 cycles -> evt_suspend pulse, suspend=1, link_state=2. An rx_activity pulse at cycle 2999 instead restarts the count, with suspend at 5999.
3. SUSPEND, K for 20 cycles -> link_state=3. Then SE0 2 cycles, then J -> evt_resume pulse, suspend=0, link_state=1.
4. SUSPEND with rwu_ena=1, rwu_req at 100 cycles -> tx_en rises at 5000 cycles after suspend entry, tx_dn=1/tx_dp=0 held exactly 2000 cycles, then link_state=3. A repeat with rwu_ena=0 -> tx_en never asserts.
5. SUSPEND then SE0 for 2500 cycles -> evt_reset pulse, usb_rst=1, suspend=0. A K of 19 cycles then J in SUSPEND -> no resume.
6. Async rst asserted mid RWU_DRIVE -> tx_en=0 immediately (asynchronously), link_state=0, usb_rst=1.
